// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if
// Command/response bus between a requester and the SPI master sequencer.
//
// Signals:
//   cmd_valid  requester has a command (held until accepted)
//   cmd_ready  sequencer can accept a command
//   cmd_type   00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//   cmd_data   address or data byte
//   rsp_valid  one-cycle pulse, rsp_data has just been updated
//   rsp_data   byte returned by the last read-data frame
//   busy       high from acceptance until the sequencer is idle again
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. The requester keeps cmd_type/cmd_data stable while
// cmd_valid is high and not yet accepted; after the transfer edge the values
// are don't-care. There is no backpressure on the response side: rsp_valid is
// a pulse and rsp_data holds until the next read-data completion.
//
// Modports:
//   master  requester side (drives the command)
//   slave   sequencer side (drives ready, response and busy)
interface spi_master_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;

    modport master (
        output cmd_valid, cmd_type, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// Single-requester SPI master sequencer. Takes one command per transaction,
// serialises it as the slave's 11-bit frame {dir, type[1:0], byte} MSB first
// on MOSI under SS_n, and for read-data commands captures the 8-bit MISO reply.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        command/response interface (slave modport)
//   SS_n       slave select, active low
//   MOSI       serial data to slave
//   MISO       serial data from slave
//   state_dbg  current sequencer state (encoding of state_t)
//
// Frame timing relative to the accept edge A:
//   A+1         SS_n falls (START)
//   A+2..A+12   11 MOSI bits (SHIFT)
//   non-read:   SS_n held low TAIL more cycles, then rises
//   read-data:  READ_LAT idle cycles, 8 MISO samples, then SS_n rises with
//               rsp_data/rsp_valid updated on the same edge
//   then GAP cycles with SS_n high and cmd_ready low before IDLE.
// All outputs are registered.
module spi_master_ctrl #(
    parameter int TAIL     = 2,   // 0..15
    parameter int READ_LAT = 2,   // 1..15
    parameter int GAP      = 1    // 1..15
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_master_ctrl_if.slave    bus,
    output logic                SS_n,
    output logic                MOSI,
    input  logic                MISO,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        TAILW = 3'd3,
        WAIT  = 3'd4,
        RECV  = 3'd5,
        GAPW  = 3'd6
    } state_t;

    // Wait counter terminal values. WAIT and GAPW count from 0 and leave on
    // the last count; TAILW needs one extra edge to drop the last MOSI bit
    // back to 0 before holding, so it leaves on TAIL itself.
    localparam logic [3:0] TAIL_LAST = 4'(TAIL);
    localparam logic [3:0] RL_LAST   = 4'(READ_LAT - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

    state_t      state;
    logic [10:0] tx_shift;
    logic [7:0]  rx_shift;
    logic [3:0]  bit_cnt;
    logic [3:0]  wait_cnt;
    logic        is_rd;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tx_shift      <= '0;
            rx_shift      <= '0;
            bit_cnt       <= '0;
            wait_cnt      <= '0;
            is_rd         <= 1'b0;
            SS_n          <= 1'b1;
            MOSI          <= 1'b0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        // Leading bit repeats type[1]: the slave's direction bit.
                        tx_shift      <= {bus.cmd_type[1], bus.cmd_type, bus.cmd_data};
                        is_rd         <= &bus.cmd_type;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        state         <= START;
                    end else begin
                        // Also the first ready edge after reset release.
                        bus.cmd_ready <= 1'b1;
                    end
                end

                START: begin
                    SS_n    <= 1'b0;
                    MOSI    <= 1'b0;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end

                SHIFT: begin
                    MOSI     <= tx_shift[10];
                    tx_shift <= {tx_shift[9:0], 1'b0};
                    wait_cnt <= '0;
                    if (bit_cnt == 4'd10) begin
                        bit_cnt <= '0;
                        state   <= is_rd ? WAIT : TAILW;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end

                TAILW: begin
                    MOSI <= 1'b0;
                    if (wait_cnt == TAIL_LAST) begin
                        SS_n     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= GAPW;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                WAIT: begin
                    MOSI <= 1'b0;
                    if (wait_cnt == RL_LAST) begin
                        wait_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= RECV;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                RECV: begin
                    // Eight sampling edges (bit_cnt 0..7), then one closing
                    // edge that raises SS_n and publishes the byte.
                    if (bit_cnt == 4'd8) begin
                        SS_n          <= 1'b1;
                        bus.rsp_data  <= rx_shift;
                        bus.rsp_valid <= 1'b1;
                        bit_cnt       <= '0;
                        wait_cnt      <= '0;
                        state         <= GAPW;
                    end else begin
                        rx_shift <= {rx_shift[6:0], MISO};
                        bit_cnt  <= bit_cnt + 4'd1;
                    end
                end

                GAPW: begin
                    if (wait_cnt == GAP_LAST) begin
                        wait_cnt      <= '0;
                        bus.cmd_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
